// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: glyphs, position selects, codes.
// Imported by the capture block, its decoder and the matching driver.
package seven_seg_pkg;

    // Active-low glyphs on {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h58;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_OVF   = 7'h09;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Active-low one-hot position selects
    localparam logic [3:0] SEL_0    = 4'b1110;
    localparam logic [3:0] SEL_1    = 4'b1101;
    localparam logic [3:0] SEL_2    = 4'b1011;
    localparam logic [3:0] SEL_3    = 4'b0111;
    localparam logic [3:0] SEL_NONE = 4'b1111;

    localparam logic [3:0] CODE_OVF   = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_BAD   = 4'hF;

    function automatic logic sel_one(logic [3:0] d);
        return $countones(d) == 3;
    endfunction

    function automatic logic sel_multi(logic [3:0] d);
        return $countones(d) <= 2;
    endfunction

    function automatic logic [1:0] sel_idx(logic [3:0] d);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!d[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// Multiplexed seven-segment display bus (active-low seg/dig).
// master: display driver side; slave: capture side.
interface seven_seg_capture_if;
    logic [7:0] seg;
    logic [3:0] dig;

    modport master (output seg, output dig);
    modport slave  (input  seg, input  dig);
endinterface

// File: rtl/seven_seg_decode.sv
// Combinational glyph to digit code decoder.
// Ports: glyph_i[6:0] active-low {g..a}; code_o[3:0] digit code.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic [3:0] code_o
);

    always_comb begin
        code_o = CODE_BAD;
        unique case (glyph_i)
            GLYPH_0:     code_o = 4'd0;
            GLYPH_1:     code_o = 4'd1;
            GLYPH_2:     code_o = 4'd2;
            GLYPH_3:     code_o = 4'd3;
            GLYPH_4:     code_o = 4'd4;
            GLYPH_5:     code_o = 4'd5;
            GLYPH_6:     code_o = 4'd6;
            GLYPH_7:     code_o = 4'd7;
            GLYPH_8:     code_o = 4'd8;
            GLYPH_9:     code_o = 4'd9;
            GLYPH_OVF:   code_o = CODE_OVF;
            GLYPH_BLANK: code_o = CODE_BLANK;
            default:     code_o = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed seven-segment bus into per-position digit codes.
// Ports: clk, rstn (async low), bus (slave), digits, valid, stale, upd,
// upd_idx, sel_err, dp (only with SEVEN_SEG_CAPTURE_DP_EN defined).
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32'd5000000
) (
    input  logic                clk,
    input  logic                rstn,
    seven_seg_capture_if.slave  bus,
    output logic [15:0]         digits,
    output logic [3:0]          valid,
    output logic [3:0]          stale,
    output logic                upd,
    output logic [1:0]          upd_idx,
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    output logic [3:0]          dp,
`endif
    output logic                sel_err
);

    logic [6:0]  seg_q;
    logic [3:0]  dig_q;
    logic [7:0]  stab_q, stab_d;
    logic        committed_q, committed_d;
    logic        same, commit_pt, wr;
    logic [1:0]  idx;
    logic [3:0]  code;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  stale_q, stale_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;
    logic        sel_err_q, sel_err_d;
    logic [31:0] age_q [4];
    logic [31:0] age_d [4];

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    logic        dpb_q;
    logic [3:0]  dp_q, dp_d;
    assign same = ({bus.seg, bus.dig} == {dpb_q, seg_q, dig_q});
`else
    // Decimal point is ignored entirely: it never disturbs stability.
    assign same = ({bus.seg[6:0], bus.dig} == {seg_q, dig_q});
`endif

    seven_seg_decode u_dec (
        .glyph_i (seg_q),
        .code_o  (code)
    );

    // Evaluated on the incoming sample, so the k-th identical sample
    // (counting the first as 0) commits on its own edge.
    assign stab_d = !same ? 8'd0 :
                    (stab_q == 8'hFF) ? stab_q : stab_q + 8'd1;
    assign commit_pt = same && !committed_q &&
                       (stab_d == 8'(STABLE_CYCLES - 1));
    assign committed_d = same && (committed_q || commit_pt);
    assign wr  = commit_pt && sel_one(dig_q);
    assign idx = sel_idx(dig_q);

    always_comb begin
        digits_d  = digits_q;
        valid_d   = valid_q;
        stale_d   = stale_q;
        upd_d     = wr;
        upd_idx_d = upd_idx_q;
        sel_err_d = sel_err_q | (commit_pt && sel_multi(dig_q));
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        dp_d      = dp_q;
`endif
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_q[i];
            if (valid_q[i] && age_q[i] != 32'd0) begin
                age_d[i] = age_q[i] - 32'd1;
                if (age_q[i] == 32'd1) stale_d[i] = 1'b1;
            end
        end
        // Commit is applied last so it wins over a same-edge expiry.
        if (wr) begin
            digits_d[{idx, 2'b00} +: 4] = code;
            valid_d[idx]  = 1'b1;
            stale_d[idx]  = 1'b0;
            age_d[idx]    = TIMEOUT_CYCLES;
            upd_idx_d     = idx;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dp_d[idx]     = ~dpb_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_q       <= 7'h7F;
            dig_q       <= SEL_NONE;
            stab_q      <= 8'd0;
            committed_q <= 1'b0;
            digits_q    <= 16'h0;
            valid_q     <= 4'h0;
            stale_q     <= 4'h0;
            upd_q       <= 1'b0;
            upd_idx_q   <= 2'd0;
            sel_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) age_q[i] <= 32'd0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dpb_q       <= 1'b1;
            dp_q        <= 4'h0;
`endif
        end else begin
            seg_q       <= bus.seg[6:0];
            dig_q       <= bus.dig;
            stab_q      <= stab_d;
            committed_q <= committed_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            stale_q     <= stale_d;
            upd_q       <= upd_d;
            upd_idx_q   <= upd_idx_d;
            sel_err_q   <= sel_err_d;
            for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
`ifdef SEVEN_SEG_CAPTURE_DP_EN
            dpb_q       <= bus.seg[7];
            dp_q        <= dp_d;
`endif
        end
    end

    assign digits  = digits_q;
    assign valid   = valid_q;
    assign stale   = stale_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;
    assign sel_err = sel_err_q;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign dp      = dp_q;
`endif

endmodule
